octree_walker: RTL and testbench
================================

// Module: octree_walker
// PURPOSE
// - Read-side client of the octree node ROM: walks the octree from the root down to the leaf that contains a query point.
// - Issues one registered ROM read per level, decodes each node word and returns the leaf payload over a valid/ready response.
// - Sits between the ray-march stepper (query producer) and the octree node ROM (1-cycle registered read, ren-gated).
// PARAMETERS
// - ADDRESS_WIDTH  32  ROM address width
// - DATA_WIDTH     32  ROM node word width
// - COORD_WIDTH    8   width of each query coordinate x/y/z
// - MAX_DEPTH      8   maximum levels walked; must be <= COORD_WIDTH
// - ROM_DEPTH      38  number of valid ROM words; addresses >= ROM_DEPTH are illegal
// PORTS
// - clk            in   1              single clock, all logic on posedge
// - rst_n          in   1              synchronous active-low reset
// - req_valid      in   1              query present
// - req_ready      out  1              walker can accept a query
// - req_x/y/z      in   COORD_WIDTH    query point, unsigned
// - rsp_valid      out  1              result present
// - rsp_ready      in   1              consumer accepts result
// - rsp_data       out  8              leaf payload (node[7:0])
// - rsp_depth      out  4              number of internal nodes traversed
// - rsp_error      out  1              walk failed; rsp_data = 0
// - rom_addr       out  ADDRESS_WIDTH  ROM read address
// - rom_ren        out  1              ROM read enable
// - rom_dout       in   DATA_WIDTH     ROM data, valid the cycle after rom_ren
// BEHAVIOUR
// - Node word: bit31 = leaf. Leaf: [7:0] payload. Internal: [23:0] child base; child i at base+i, i in 0..7.
// - Root is at address 0. Octant at level L uses bit b = COORD_WIDTH-1-L: idx = {x[b], y[b], z[b]}.
// - Reset: state IDLE; req_ready=1, rsp_valid=0, rom_ren=0, rom_addr=0, rsp_data=0, rsp_depth=0, rsp_error=0.
// - IDLE: req_ready=1. On req_valid&&req_ready, latch x/y/z, set addr=0, level=0, then go to ISSUE.
// - ISSUE: rom_ren=1, rom_addr=addr, for exactly one cycle; then go to EVAL. req_ready=0 in every state except IDLE.
// - EVAL: rom_ren=0; decode rom_dout (the ROM holds dout while ren is low).
//   - Leaf: capture payload; depth=level; error=0; go to RESP.
//   - Internal: next = base + idx(level), computed in ADDRESS_WIDTH.
//     - next >= ROM_DEPTH, or level+1 == MAX_DEPTH: error=1, data=0, depth=level+1; go to RESP.
//     - Otherwise: addr=next, level++, go to ISSUE.
// - RESP: rsp_valid=1; outputs stable until rsp_valid&&rsp_ready, then return to IDLE.
//   - No same-cycle accept of a new query; req_ready rises the cycle after the response handshake.
// - Latency: handshake at edge k -> rsp_valid first high in cycle k+3+2*d, where d = internal nodes traversed.
// - Back-pressure: rsp_ready low holds RESP indefinitely; no ROM reads are issued while waiting.
// - Reset mid-walk: abort immediately to reset values. Any in-flight ROM data is ignored. No response is emitted.
// - At most one walk is in flight; inputs are latched, so req_x/y/z may change after the handshake.
// STRUCTURE
// - octree_pkg: node field constants (LEAF_BIT=31, CHILD_BASE_MSB=23, PAYLOAD_MSB=7), walker_state_e {IDLE, ISSUE, EVAL, RESP}, node decode function.
// - Sub-module octant_select: combinational; (x, y, z, level) -> 3-bit child index. Shared with the ray stepper.
// - Top: FSM, latched query registers, address/level registers, response registers.
// TESTING
// - Root leaf: mem[0]=0x8000_002A, any query -> rsp_data=0x2A, depth=0, error=0; rsp_valid 3 cycles after handshake; exactly one rom_ren pulse at addr 0.
// - Two-level walk: mem[0]=0x0000_0001, mem[1..8]=0x8000_0010+i, query (0x80,0x00,0x80) -> idx=5, rom_addr sequence 0,6, rsp_data=0x15, depth=1, rsp_valid at k+5.
// - Out-of-range child: mem[0]=0x0000_0024, query (0xFF,0xFF,0xFF) -> next=43 >= 38, error=1, data=0, depth=1; no second ROM read.
// - Depth limit: MAX_DEPTH=2, chain of internal nodes mem[0]=1, mem[1]=9 -> error=1, depth=2 after two reads.
// - Back-pressure: hold rsp_ready=0 for 10 cycles -> rsp outputs stable, req_ready=0, rom_ren=0 throughout; release -> IDLE the next cycle.
// - Reset mid-walk: assert rst_n=0 in EVAL of a two-level walk -> next cycle all outputs at reset values; no rsp_valid; a fresh query then completes normally.

Source files
------------

// File: rtl/octree_pkg.sv
// octree_pkg: node word field positions, walker FSM states and node decode shared by the octree clients.
package octree_pkg;
  localparam int LEAF_BIT = 31;
  localparam int CHILD_BASE_MSB = 23;
  localparam int PAYLOAD_MSB = 7;
  typedef enum logic [1:0] {IDLE, ISSUE, EVAL, RESP} walker_state_e;
  typedef struct packed {
    logic                    leaf;
    logic [CHILD_BASE_MSB:0] base;
    logic [PAYLOAD_MSB:0]    payload;
  } node_t;
  // The child base and the payload overlap; which one is meaningful depends on the leaf bit.
  function automatic node_t decode_node(input logic [LEAF_BIT:0] w);
    return '{leaf: w[LEAF_BIT], base: w[CHILD_BASE_MSB:0], payload: w[PAYLOAD_MSB:0]};
  endfunction
endpackage

// File: rtl/octant_select.sv
// octant_select: picks the child octant {x[b], y[b], z[b]} for tree level L, where b = COORD_WIDTH-1-L.
// Ports: x/y/z query coordinates, level current tree level, idx 3-bit child index.
module octant_select #(
  parameter int COORD_WIDTH = 8,
  parameter int LEVEL_WIDTH = 4
) (
  input  logic [COORD_WIDTH-1:0] x,
  input  logic [COORD_WIDTH-1:0] y,
  input  logic [COORD_WIDTH-1:0] z,
  input  logic [LEVEL_WIDTH-1:0] level,
  output logic [2:0]             idx
);
  localparam int BW = COORD_WIDTH > 1 ? $clog2(COORD_WIDTH) : 1;
  logic [BW-1:0] b;
  assign b = BW'(COORD_WIDTH - 1) - BW'(level);
  assign idx = {x[b], y[b], z[b]};
endmodule

// File: rtl/octree_walker.sv
// octree_walker: walks the octree node ROM from the root to the leaf containing a query point.
// Ports: clk/rst_n (sync active-low); req_* query handshake with x/y/z point;
// rsp_* result handshake with leaf payload, internal-node depth and error flag;
// rom_addr/rom_ren/rom_dout one-cycle registered ROM read port.
module octree_walker
  import octree_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int COORD_WIDTH   = 8,
  parameter int MAX_DEPTH     = 8,
  parameter int ROM_DEPTH     = 38
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [COORD_WIDTH-1:0]   req_x,
  input  logic [COORD_WIDTH-1:0]   req_y,
  input  logic [COORD_WIDTH-1:0]   req_z,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_data,
  output logic [3:0]               rsp_depth,
  output logic                     rsp_error,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  output logic                     rom_ren,
  input  logic [DATA_WIDTH-1:0]    rom_dout
);
  walker_state_e state_q, state_d;
  logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d, next_addr;
  logic [3:0] level_q, level_d, depth_q, depth_d;
  logic [7:0] data_q, data_d;
  logic error_q, error_d, rom_ren_q, rom_ren_d, req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [2:0] idx;
  logic unused_dout;
  node_t node;
  assign unused_dout = ^rom_dout;
  assign node = decode_node(rom_dout[LEAF_BIT:0]);
  octant_select #(.COORD_WIDTH(COORD_WIDTH), .LEVEL_WIDTH(4)) u_octant (
    .x(x_q), .y(y_q), .z(z_q), .level(level_q), .idx(idx)
  );
  assign next_addr = ADDRESS_WIDTH'(node.base) + ADDRESS_WIDTH'(idx);
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    addr_d = addr_q;
    level_d = level_q;
    data_d = data_q;
    depth_d = depth_q;
    error_d = error_q;
    case (state_q)
      IDLE: if (req_valid) begin
        x_d = req_x;
        y_d = req_y;
        z_d = req_z;
        addr_d = '0;
        level_d = '0;
        state_d = ISSUE;
      end
      ISSUE: state_d = EVAL;
      EVAL: if (node.leaf) begin
        data_d = node.payload;
        depth_d = level_q;
        error_d = 1'b0;
        state_d = RESP;
      end else if (next_addr >= ADDRESS_WIDTH'(ROM_DEPTH) || level_q + 4'd1 == 4'(MAX_DEPTH)) begin
        data_d = '0;
        depth_d = level_q + 4'd1;
        error_d = 1'b1;
        state_d = RESP;
      end else begin
        addr_d = next_addr;
        level_d = level_q + 4'd1;
        state_d = ISSUE;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    // Handshake/strobe outputs are registered copies of the next state.
    rom_ren_d = state_d == ISSUE;
    req_ready_d = state_d == IDLE;
    rsp_valid_d = state_d == RESP;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      addr_q <= '0;
      level_q <= '0;
      data_q <= '0;
      depth_q <= '0;
      error_q <= 1'b0;
      rom_ren_q <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      addr_q <= addr_d;
      level_q <= level_d;
      data_q <= data_d;
      depth_q <= depth_d;
      error_q <= error_d;
      rom_ren_q <= rom_ren_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = data_q;
  assign rsp_depth = depth_q;
  assign rsp_error = error_q;
  assign rom_addr = addr_q;
  assign rom_ren = rom_ren_q;
endmodule

// File: tb/tb_octree_walker.sv
// tb_octree_walker: runs directed queries against two walkers (MAX_DEPTH 8 and 2) sharing one node memory.
module tb_octree_walker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic rsp_ready = 1'b1;
  logic [7:0] req_x = '0, req_y = '0, req_z = '0;
  logic req_ready [2];
  logic rsp_valid [2];
  logic rsp_error [2];
  logic rom_ren [2];
  logic [7:0] rsp_data [2];
  logic [3:0] rsp_depth [2];
  logic [31:0] rom_addr [2];
  logic [31:0] mem [64];
  int passed = 0, total = 0;
  // model state per walker
  logic [31:0] exp_reads [2][8];
  int exp_n [2], rd_i [2], cnt [2], done [2];
  logic [7:0] exp_data [2];
  logic [3:0] exp_depth [2];
  logic exp_err [2];
  bit pending [2], seen [2], after_rsp [2];
  logic [7:0] last_data [2];
  logic [3:0] last_depth [2];
  logic last_err [2];
  int last_lat [2], last_reads [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] dout;
    octree_walker #(.MAX_DEPTH(g == 0 ? 8 : 2)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[g]),
      .req_x(req_x), .req_y(req_y), .req_z(req_z),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[g]),
      .rsp_depth(rsp_depth[g]), .rsp_error(rsp_error[g]),
      .rom_addr(rom_addr[g]), .rom_ren(rom_ren[g]), .rom_dout(dout)
    );
    always @(posedge clk) if (rom_ren[g]) dout <= rom_addr[g] < 64 ? mem[rom_addr[g][5:0]] : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s dut%0d got=%0h expected=%0h", name, g, act, exp);
  endtask

  // Plain descent from the root: list of addresses read and the final result.
  function automatic void walk(input int g, input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    int maxd = g == 0 ? 8 : 2;
    int lvl = 0;
    logic [31:0] a = 0, w, nxt;
    exp_n[g] = 0;
    while (1) begin
      exp_reads[g][exp_n[g]] = a;
      exp_n[g]++;
      w = mem[a[5:0]];
      if (w[31]) begin
        exp_data[g] = w[7:0];
        exp_depth[g] = 4'(lvl);
        exp_err[g] = 1'b0;
        break;
      end
      nxt = {8'h0, w[23:0]} + {29'h0, x[7-lvl], y[7-lvl], z[7-lvl]};
      if (nxt >= 38 || lvl + 1 == maxd) begin
        exp_data[g] = 8'h0;
        exp_depth[g] = 4'(lvl + 1);
        exp_err[g] = 1'b1;
        break;
      end
      a = nxt;
      lvl++;
    end
  endfunction

  // Inputs change #1 after posedge, so values seen here are what the next posedge samples.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        pending[g] = 0;
        seen[g] = 0;
        after_rsp[g] = 0;
      end else begin
        if (pending[g]) cnt[g]++;
        if (rom_ren[g]) begin
          chk("rom_addr", g, rom_addr[g], pending[g] && rd_i[g] < exp_n[g] ? exp_reads[g][rd_i[g]] : 32'hFFFF_FFFF);
          rd_i[g]++;
        end
        if (rsp_valid[g]) begin
          chk("rsp_expected", g, 32'(pending[g]), 1);
          if (pending[g]) begin
            if (!seen[g]) begin
              seen[g] = 1;
              chk("latency", g, cnt[g], 1 + 2 * exp_n[g]);
              chk("read_count", g, rd_i[g], exp_n[g]);
              last_data[g] = rsp_data[g];
              last_depth[g] = rsp_depth[g];
              last_err[g] = rsp_error[g];
              last_lat[g] = cnt[g];
              last_reads[g] = rd_i[g];
            end
            chk("rsp_data", g, rsp_data[g], exp_data[g]);
            chk("rsp_depth", g, rsp_depth[g], exp_depth[g]);
            chk("rsp_error", g, rsp_error[g], exp_err[g]);
            chk("req_ready_in_rsp", g, req_ready[g], 0);
            chk("rom_ren_in_rsp", g, rom_ren[g], 0);
            if (rsp_ready) begin
              pending[g] = 0;
              done[g]++;
              after_rsp[g] = 1;
            end
          end
        end else if (after_rsp[g]) begin
          chk("req_ready_after_rsp", g, req_ready[g], 1);
          after_rsp[g] = 0;
        end
        if (req_valid && req_ready[g]) begin
          walk(g, req_x, req_y, req_z);
          pending[g] = 1;
          seen[g] = 0;
          cnt[g] = 0;
          rd_i[g] = 0;
        end
      end
    end
  end

  task automatic clr_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic start(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    int t = 0;
    while (!(req_ready[0] && req_ready[1]) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) chk("ready_timeout", 0, 32'(t), 0);
    req_valid = 1'b1;
    req_x = x;
    req_y = y;
    req_z = z;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_x = 8'($urandom);
    req_y = 8'($urandom);
    req_z = 8'($urandom);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done[0] + done[1] < target && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) chk("rsp_timeout", 0, 32'(t), 0);
  endtask

  task automatic run(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    int target = done[0] + done[1] + 2;
    start(x, y, z);
    wait_done(target);
  endtask

  task automatic lit(input int g, input logic [7:0] d, input logic [3:0] dp, input logic e, input int lat);
    chk("lit_data", g, last_data[g], d);
    chk("lit_depth", g, last_depth[g], dp);
    chk("lit_error", g, last_err[g], e);
    chk("lit_latency", g, last_lat[g], lat);
  endtask

  task automatic chk_reset();
    for (int g = 0; g < 2; g++) begin
      chk("rst_req_ready", g, req_ready[g], 1);
      chk("rst_rsp_valid", g, rsp_valid[g], 0);
      chk("rst_rom_ren", g, rom_ren[g], 0);
      chk("rst_rom_addr", g, rom_addr[g], 0);
      chk("rst_rsp_data", g, rsp_data[g], 0);
      chk("rst_rsp_depth", g, rsp_depth[g], 0);
      chk("rst_rsp_error", g, rsp_error[g], 0);
    end
  endtask

  task automatic setup_two_level();
    clr_mem();
    mem[0] = 32'h0000_0001;
    for (int i = 0; i < 8; i++) mem[1+i] = 32'h8000_0010 + i;
  endtask

  initial begin
    int target;
    for (int g = 0; g < 2; g++) begin
      done[g] = 0;
      cnt[g] = 0;
      rd_i[g] = 0;
    end
    clr_mem();
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    // root leaf
    mem[0] = 32'h8000_002A;
    run(8'h12, 8'h34, 8'h56);
    lit(0, 8'h2A, 4'd0, 1'b0, 3);
    chk("lit_reads", 0, last_reads[0], 1);
    // two-level walk, idx 5 -> address 6
    setup_two_level();
    run(8'h80, 8'h00, 8'h80);
    lit(0, 8'h15, 4'd1, 1'b0, 5);
    lit(1, 8'h15, 4'd1, 1'b0, 5);
    // out-of-range child 36+7=43
    clr_mem();
    mem[0] = 32'h0000_0024;
    run(8'hFF, 8'hFF, 8'hFF);
    lit(0, 8'h00, 4'd1, 1'b1, 3);
    chk("lit_reads", 0, last_reads[0], 1);
    // last legal child 30+7=37
    clr_mem();
    mem[0] = 32'h0000_001E;
    mem[37] = 32'h8000_00AB;
    run(8'hFF, 8'hFF, 8'hFF);
    lit(0, 8'hAB, 4'd1, 1'b0, 5);
    // depth limit on the MAX_DEPTH=2 walker; the deep walker reaches the leaf at 9
    clr_mem();
    mem[0] = 32'h0000_0001;
    mem[1] = 32'h0000_0009;
    mem[9] = 32'h8000_0077;
    run(8'h00, 8'h00, 8'h00);
    lit(1, 8'h00, 4'd2, 1'b1, 5);
    chk("lit_reads", 1, last_reads[1], 2);
    lit(0, 8'h77, 4'd2, 1'b0, 7);
    // three levels with a different octant per level: 0 -> 3 -> 16 -> 21
    clr_mem();
    mem[0] = 32'h0000_0001;
    mem[3] = 32'h0000_000A;
    mem[16] = 32'h0000_0014;
    mem[21] = 32'h8000_0099;
    run(8'h40, 8'hC0, 8'h20);
    lit(0, 8'h99, 4'd3, 1'b0, 9);
    lit(1, 8'h00, 4'd2, 1'b1, 5);
    // back-pressure: response held for 10 cycles
    setup_two_level();
    rsp_ready = 1'b0;
    target = done[0] + done[1] + 2;
    start(8'h80, 8'h00, 8'h80);
    repeat (16) @(posedge clk);
    #1;
    chk("bp_valid", 0, rsp_valid[0], 1);
    chk("bp_data", 0, rsp_data[0], 8'h15);
    chk("bp_rom_ren", 0, rom_ren[0], 0);
    rsp_ready = 1'b1;
    wait_done(target);
    // reset in the first EVAL of a two-level walk
    start(8'h80, 8'h00, 8'h80);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_valid", 0, rsp_valid[0], 0);
    mem[0] = 32'h8000_005C;
    run(8'h01, 8'h02, 8'h03);
    lit(0, 8'h5C, 4'd0, 1'b0, 3);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
